// File: rtl/seq_shifter32_pkg.sv
// Shared constants, encodings and the effective-count helper for seq_shifter32.
// Optional feature macro: SEQ_SHIFTER32_ROTATE_EN (sel=11 becomes rotate right).
package seq_shifter32_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 6;

  // Op-select encoding shared with the single-cycle ALU shifter.
  localparam logic [1:0] SEL_PASS = 2'b00;
  localparam logic [1:0] SEL_SHL  = 2'b01;
  localparam logic [1:0] SEL_SHR  = 2'b10;
  localparam logic [1:0] SEL_ALT  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;

  // Number of 1-bit steps for an op; any amount >= 32 saturates to 32 for shifts.
  function automatic logic [CNT_W-1:0] eff_count(logic [1:0] sel, logic [WIDTH-1:0] amt);
    logic [CNT_W-1:0] n;
    n = '0;
    case (sel)
      SEL_SHL, SEL_SHR: n = (|amt[WIDTH-1:5]) ? CNT_W'(WIDTH) : {1'b0, amt[4:0]};
`ifdef SEQ_SHIFTER32_ROTATE_EN
      SEL_ALT:          n = {1'b0, amt[4:0]};
`endif
      default:          n = '0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/shift_step32.sv
// Combinational single-bit shift step: left inserts 0 at bit 0, right inserts 0
// (or bit 0 when rotating) at bit 31.
module shift_step32 (
  input  logic [31:0] value_i,
  input  logic        left_i,
  input  logic        rot_i,
  output logic [31:0] next_o
);

  // One-position shift or rotate of the current value.
  always_comb begin
    next_o = value_i;
    if (left_i) begin
      next_o = {value_i[30:0], 1'b0};
    end else begin
      next_o = {(rot_i & value_i[0]), value_i[31:1]};
    end
  end

endmodule

// File: rtl/seq_shifter32.sv
// Multi-cycle 32-bit shifter with valid/ready request and response channels.
// One bit position per clock. Optional macro SEQ_SHIFTER32_ROTATE_EN turns
// sel=11 into rotate right by b[4:0]; undefined, sel=11 is a passthrough.
module seq_shifter32
  import seq_shifter32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [1:0]         sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   step_next;
  logic               rot_flag;

`ifdef SEQ_SHIFTER32_ROTATE_EN
  assign rot_flag = (sel_q == SEL_ALT);
`else
  assign rot_flag = 1'b0;
`endif

  shift_step32 u_step (
    .value_i (res_q),
    .left_i  (sel_q == SEL_SHL),
    .rot_i   (rot_flag),
    .next_o  (step_next)
  );

  // Next-state, datapath update and handshake outputs (all decoded from state).
  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          res_d   = a;
          sel_d   = sel;
          cnt_d   = eff_count(sel, b);
          state_d = (cnt_d == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        res_d = step_next;
        cnt_d = cnt_q - 1'b1;
        // The edge applying the final step also moves to DONE.
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, result, op and count registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      sel_q   <= SEL_PASS;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out = res_q;

endmodule

// File: tb/tb_seq_shifter32.sv
// Directed self-checking bench for seq_shifter32. Honours SEQ_SHIFTER32_ROTATE_EN
// for the sel=11 expectations.
module tb_seq_shifter32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;

  seq_shifter32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  always #5 clk = ~clk;

  // Present a request for exactly one rising edge; returns at the negedge after accept.
  task automatic drive_req(input logic [31:0] av, input logic [31:0] bv, input logic [1:0] sv);
    @(negedge clk);
    a = av; b = bv; sel = sv; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Latency in negedges after the accept edge until out_valid; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sel = 2'b00;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset_out got %h want 0", out); end
    rst_n = 1'b1;
    drive_req(32'hFFFF_FFFF, 32'd20, 2'b01);
    repeat (5) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready got %b want 0", in_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL abort_out got %h want 0", out); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_result got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_shift_left();
    int lat;
    drive_req(32'h0000_0001, 32'd4, 2'b01);
    wait_valid(lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL shl_latency got %0d want 5", lat); end
    checks++; if (out !== 32'h0000_0010) begin errors++; $display("FAIL shl_out got %h want 00000010", out); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL done_in_ready got %b want 0", in_ready); end
    consume();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_consume_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_consume_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_shift_right_stall();
    int lat;
    int bad;
    drive_req(32'h8000_0000, 32'd31, 2'b10);
    wait_valid(lat);
    checks++; if (lat !== 32) begin errors++; $display("FAIL shr_latency got %0d want 32", lat); end
    checks++; if (out !== 32'h0000_0001) begin errors++; $display("FAIL shr_out got %h want 00000001", out); end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out !== 32'h0000_0001) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL shr_stall_stable got %0d bad cycles want 0", bad); end
    consume();
  endtask

  task automatic test_out_of_range();
    int lat;
    drive_req(32'hDEAD_BEEF, 32'h0000_0040, 2'b01);
    wait_valid(lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL oor_latency got %0d want 33", lat); end
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL oor_out got %h want 0", out); end
    consume();
    drive_req(32'hDEAD_BEEF, 32'h0000_0020, 2'b10);
    wait_valid(lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b32_latency got %0d want 33", lat); end
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL b32_out got %h want 0", out); end
    consume();
    drive_req(32'hDEAD_BEEF, 32'd0, 2'b10);
    wait_valid(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL b0_latency got %0d want 1", lat); end
    checks++; if (out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b0_out got %h want deadbeef", out); end
    consume();
  endtask

  task automatic test_sel_alt();
    int lat;
    drive_req(32'h0000_0003, 32'd1, 2'b11);
    wait_valid(lat);
`ifdef SEQ_SHIFTER32_ROTATE_EN
    checks++; if (lat !== 2) begin errors++; $display("FAIL rot_latency got %0d want 2", lat); end
    checks++; if (out !== 32'h8000_0001) begin errors++; $display("FAIL rot_out got %h want 80000001", out); end
`else
    checks++; if (lat !== 1) begin errors++; $display("FAIL alt_latency got %0d want 1", lat); end
    checks++; if (out !== 32'h0000_0003) begin errors++; $display("FAIL alt_out got %h want 00000003", out); end
`endif
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    drive_req(32'h0000_0001, 32'd3, 2'b01);
    // Second request held valid while busy; also perturbs a/b/sel during SHIFT.
    a = 32'h0000_00F0; b = 32'd4; sel = 2'b10; in_valid = 1'b1;
    wait_valid(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_first_latency got %0d want 4", lat); end
    checks++; if (out !== 32'h0000_0008) begin errors++; $display("FAIL b2b_first_out got %h want 00000008", out); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy_in_ready got %b want 0", in_ready); end
    consume();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_r got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_second_latency got %0d want 5", lat); end
    checks++; if (out !== 32'h0000_000F) begin errors++; $display("FAIL b2b_second_out got %h want 0000000f", out); end
    consume();
  endtask

  initial begin
    test_reset();
    test_shift_left();
    test_shift_right_stall();
    test_out_of_range();
    test_sel_alt();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_shifter32.md
# seq_shifter32

Multi-cycle, handshaked 32-bit shift unit: the sequential counterpart of the single-cycle ALU shifter, for area-constrained datapaths. It accepts an operand, a shift amount and an op select over a valid/ready request channel. It shifts one bit position per clock and returns the result over a valid/ready response channel. The op-select encoding is identical to the ALU shifter, so the two units are interchangeable behind the ALU result mux.

## Interface
Parameters:
- none (width fixed at 32; amount field fixed at 6 bits internally)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  unit idle and able to accept a request
- a  input  32  operand
- b  input  32  shift amount
- sel  input  2  op: 00 pass, 01 logical left, 10 logical right, 11 pass (or rotate right, see Configuration)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out  output  32  result; stable while out_valid is high

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1.
  - On in_valid&in_ready, latch a into the result register and latch sel.
  - Effective count n: for sel 01 and 10, n = 32 if b[31:5]≠0 or b≥32, else b[4:0]. For sel 00 (and 11 without the macro), n = 0.
  - Next state is DONE if n==0, else SHIFT.
- SHIFT: each edge applies a 1-bit shift (left: insert 0 at bit 0; right: insert 0 at bit 31) and decrements the count. The edge that applies the nth step moves the FSM to DONE.
- DONE: out_valid=1 and out holds the result. On out_valid&out_ready, go to IDLE.
- Semantic rule: the result equals the combinational shift of a by min(b,32). Any b≥32 gives 0 for left and right shifts.
- in_ready is low in SHIFT and DONE. Inputs presented there are ignored, not queued.
- Inputs are sampled only at the accept edge. Changes to a/b/sel afterwards have no effect.
- out_valid never drops without out_ready. out is unchanged while back-pressured.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, in_ready=1, out_valid=0, out=0, count=0.
- Request accepted at edge T with count n: out_valid is high from the cycle after edge T+n. So n=0 gives a one-cycle latency and n=32 gives 33 cycles.
- Response consumed at edge R: in_ready is high in the cycle after R. Minimum request spacing is n+2 cycles.
- No same-cycle accept/complete overlap: in_ready is never high while out_valid is high.
- Reset asserted in SHIFT or DONE aborts the operation immediately. A pending result is discarded and never presented.
- out is registered. No combinational path from inputs to out, out_valid or in_ready.

## Configuration
- SEQ_SHIFTER32_ROTATE_EN defined:
  - sel=11 is rotate right by b[4:0], with n = b[4:0]; bit 0 re-enters at bit 31 each step.
  - Rotate by 0 completes in one cycle with out=a.
- Undefined: sel=11 is passthrough, identical to sel=00 (n=0). No rotate logic is synthesized.

## Structure
- Shared package seq_shifter32_pkg (Verilog header):
  - sel encodings SEL_PASS=2'b00, SEL_SHL=2'b01, SEL_SHR=2'b10, SEL_ALT=2'b11
  - state encodings ST_IDLE, ST_SHIFT, ST_DONE
  - the width constant 32
- One natural sub-module: shift_step32, a combinational single-bit step. Inputs: value, direction, and rotate flag. Output: next value. It is instantiated once in the datapath.
- The FSM and the 6-bit down-counter live in the top module.

## Test plan
- Reset: rst_n low mid-SHIFT with a=32'hFFFF_FFFF, sel=01, b=20 → out_valid=0, in_ready=1, out=0 immediately. No result appears after release.
- Left shift: a=32'h0000_0001, b=4, sel=01 → out=32'h0000_0010; out_valid rises after edge T+4.
- Right shift with stall: a=32'h8000_0000, b=31, sel=10, out_ready held low 5 cycles → out=32'h0000_0001 held stable with out_valid=1 until out_ready.
- Out-of-range amount: a=32'hDEAD_BEEF, b=32'h0000_0040, sel=01 → out=0 after 32 shift steps. Also, b=0 with sel=10 → out=32'hDEAD_BEEF with one-cycle latency.
- sel=11, a=32'h0000_0003, b=1:
  - with SEQ_SHIFTER32_ROTATE_EN → out=32'h8000_0001 after edge T+1
  - without the macro → out=32'h0000_0003 after edge T
- Back-to-back and ignored input: second request held valid during busy → accepted only in the cycle after the first response handshake. Inputs changed during SHIFT do not alter the first result.
